// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_full_subtractor
//  Description : Bit-serial W-bit subtractor. Captures a, b and bin on an
//                accepted start, then resolves one difference bit per clock,
//                LSB first, through a single registered borrow. Presents the
//                parallel difference d and final borrow bout with a one-cycle
//                done strobe, W+1 cycles after start is accepted.
//                Optional build macro FS_SAT_EN: when the final borrow is 1,
//                d is loaded with 0 (unsigned saturation) instead of the
//                wrapped difference; bout still reports 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_full_subtractor #(
    parameter int W = 8
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   ra_q, ra_d;
    logic [W-1:0]   rb_q, rb_d;
    logic [W-1:0]   res_q, res_d;
    logic           br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   d_q, d_d;
    logic           bout_q, bout_d;
    logic           done_q, done_d;

    logic           w_x;
    logic           w_y;
    logic           w_diff;
    logic           w_borrow;
    logic [W-1:0]   w_result;

    // Current full-subtract cell: operand LSBs against the registered borrow.
    assign w_x      = ra_q[0];
    assign w_y      = rb_q[0];
    assign w_diff   = w_x ^ w_y ^ br_q;
    assign w_borrow = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);

`ifdef FS_SAT_EN
    // An underflowing subtraction clamps to zero.
    assign w_result = br_q ? '0 : res_q;
`else
    assign w_result = res_q;
`endif

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load on start, shift W times, then publish the result.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                res_d = {w_diff, res_q[W-1:1]};
                br_d  = w_borrow;
                ra_d  = {1'b0, ra_q[W-1:1]};
                rb_d  = {1'b0, rb_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_cnt_last) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // Result is published here; a start in this cycle chains
                // straight into the next operation with no dead cycle.
                done_d = 1'b1;
                d_d    = w_result;
                bout_d = br_q;
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_full_subtractor
//  Description : Directed self-checking bench for serial_full_subtractor, W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_full_subtractor;

    localparam int W = 8;

    logic         ck;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int n_vec  = 0;
    int n_miss = 0;

    serial_full_subtractor #(.W(W)) dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    // Run one operation. If ign_at > 0, a stray start with zero operands is
    // pulsed ign_at cycles after acceptance and must have no effect.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ibin, input logic [7:0] exp_d, input logic exp_bout,
                          input int ign_at);
        int edges;
        int busy_cnt;
        bit seen;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick;
        start = 1'b0;
        edges = 0; busy_cnt = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            if (ign_at > 0 && edges == ign_at) begin
                a = 8'h00; b = 8'h00; bin = 1'b0; start = 1'b1;
            end
            tick;
            start = 1'b0;
            edges++;
        end
        check_eq({tag, ".done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, ".latency"}, 32'(edges), 32'd9);
        check_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd8);
        check_eq({tag, ".d"}, 32'(d), 32'(exp_d));
        check_eq({tag, ".bout"}, 32'(bout), 32'(exp_bout));
        tick;
        check_eq({tag, ".done_strobe_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        int last_t;
        int pulses;
        bit any_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check_eq("reset.busy", 32'(busy), 32'd0);
        check_eq("reset.done", 32'(done), 32'd0);
        check_eq("reset.d",    32'(d),    32'd0);
        check_eq("reset.bout", 32'(bout), 32'd0);
        tick;

        run_op("5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 0);
`ifdef FS_SAT_EN
        run_op("00_01", 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op("10_10_b1", 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 0);
`else
        run_op("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0);
        run_op("10_10_b1", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 0);
`endif
        run_op("ff_00_b1", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 0);
        run_op("ignored_start", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 3);

        // Reset 4 cycles into an operation discards it.
        a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_eq("midreset.busy", 32'(busy), 32'd0);
        check_eq("midreset.d",    32'(d),    32'd0);
        check_eq("midreset.bout", 32'(bout), 32'd0);
        any_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) any_done = 1;
            tick;
        end
        check_eq("midreset.no_activity", 32'(any_done), 32'd0);
        run_op("after_reset", 8'h03, 8'h02, 1'b0, 8'h01, 1'b0, 0);

        // Start held high: back-to-back results every W+1 cycles.
        a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
        tick;
        last_t = 0; pulses = 0;
        for (int t = 1; t <= 40; t++) begin
            tick;
            if (done) begin
                pulses++;
                check_eq("b2b.interval", 32'(t - last_t), 32'd9);
                check_eq("b2b.d",        32'(d),          32'h05);
                check_eq("b2b.bout",     32'(bout),       32'd0);
                last_t = t;
            end
        end
        start = 1'b0;
        check_eq("b2b.pulses", 32'(pulses), 32'd4);
        repeat (12) tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
- Bit-serial W-bit subtractor. It is the inverse-operation counterpart of the team's registered full-adder cell.
- Loads two unsigned operands and a borrow-in on a start pulse, then performs one full-subtract step per clock, LSB first, through a single registered borrow stage.
- Presents the parallel difference and final borrow with a one-cycle done strobe.
- Used wherever the datapath needs area-cheap subtraction with relaxed latency.

Parameters:
- W, 8, operand and result width in bits (W >= 2).

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- a  input  W  minuend; captured on an accepted start.
- b  input  W  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle strobe; d and bout are valid.
- d  output  W  difference a - b - bin (mod 2^W).
- bout  output  1  final borrow-out; 1 when a < b + bin.

Behaviour:
- Reset (rst=1 at an edge), on the following edge:
  - state=IDLE.
  - busy=0, done=0, d=0, bout=0.
  - Internal shift registers, borrow register and bit counter = 0.
  - rst has priority over every other input, including mid-operation: any in-flight result is discarded.
- States:
  - IDLE: busy=0. On start=1, go to SHIFT.
  - SHIFT: busy=1; runs for exactly W cycles.
  - DONE: done=1 for exactly one cycle. busy=0 in DONE.
- Accepting start (IDLE or DONE, start=1 at an edge):
  - ra<=a, rb<=b, br<=bin, cnt<=0, state<=SHIFT.
- Each SHIFT edge:
  - x=ra[0], y=rb[0].
  - diff bit = x^y^br.
  - br <= (~x & y) | (~(x^y) & br).
  - ra and rb shift right by 1.
  - The diff bit is shifted into the MSB of the result register; the result register shifts right.
  - cnt increments. On the edge where cnt==W-1, go to DONE.
- In DONE: d is loaded from the result register, bout from br (registered, glitch-free).
- Latency: start accepted at edge k; done=1 in the cycle after edge k+W+1. That is W+1 cycles from start acceptance to done rising.
- d and bout hold their value after DONE until the next DONE or reset. They do not change during SHIFT.
- start while busy=1 is ignored: no restart, no queueing.
- Back-to-back operation: start=1 in the DONE cycle is accepted. done still pulses, and the next result follows W+1 cycles later with no dead cycle.
- DONE with start=0 goes to IDLE.
- Arithmetic: unsigned, modulo 2^W. No overflow flag apart from bout.

Optional Feature:
- Macro: FS_SAT_EN.
- Defined: when the final borrow is 1, d loads 0 instead of the wrapped difference (unsigned saturation). bout is still reported as 1.
- Not defined: d is always the modulo-2^W difference.
- Latency and handshake are identical in both builds.

Test Plan (W=8):
- Reset, then a=0x5A, b=0x3C, bin=0, start pulse -> done 9 cycles after acceptance; d=0x1E, bout=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1. With FS_SAT_EN defined: d=0x00, bout=1.
- a=0x10, b=0x10, bin=1 -> d=0xFF, bout=1. Separately, a=0xFF, b=0x00, bin=1 -> d=0xFE, bout=0.
- Start with a=0x80, b=0x01. Pulse start again with a=0x00, b=0x00 three cycles later -> second start ignored; d=0x7F, bout=0.
- Assert rst for one cycle, 4 cycles into an operation -> busy=0, done never pulses, d=0, bout=0. A new start afterwards, a=0x03, b=0x02 -> d=0x01.
- start held high continuously with operands 0x09-0x04 -> done pulses every 9 cycles; d=0x05 each time; no missed strobes.
